control_seq: RTL

CONTROL_SEQ -- requirements
Module: control_seq

---
 rtl/control_seq.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/control_seq.sv
// control_seq: microcoded control sequencer.
// Decodes one microinstruction word per clock into bus selects, bus enables
// and jump conditions, and steps a T-state counter through each opcode's
// microcode. uaddr = {opcode, tstate} addresses an external microcode ROM
// whose data comes back combinationally on uinstr.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | sequencer steps tstate each clock unless stalled
// ST_HALTED  | HALT decoded; tstate, opcode and instr_count frozen until reset
module control_seq #(
  parameter int TB  = 3,
  parameter int OPW = 8,
  parameter int UW  = 16,
  parameter int CW  = 16
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [UW-1:0]                       uinstr,
  input  logic [OPW-1:0]                      bus_in,
  input  logic                                Z,
  input  logic                                LT,
  input  logic                                stall,
  output logic [OPW+TB-1:0]                   uaddr,
  output logic [TB-1:0]                       tstate,
  output logic                                EO,
  output logic                                S8,
  output logic [5:0]                          ALU_flags,
  output logic                                PO,
  output logic                                IOH,
  output logic                                IOL,
  output logic                                MO,
  output logic                                DO,
  output logic                                AI,
  output logic                                II,
  output logic                                MI,
  output logic                                XI,
  output logic                                YI,
  output logic                                DI,
  output logic                                RT,
  output logic                                PP,
  output logic                                JZ,
  output logic                                JGT,
  output logic                                JLT,
  output logic                                JMP,
  output logic [((UW > 16) ? (UW - 16) : 1)-1:0] ext,
  output logic                                halted,
  output logic [CW-1:0]                       instr_count
);

  localparam logic [TB-1:0] T_ZERO = '0;
  localparam logic [TB-1:0] T_LAST = '1;
  localparam logic [TB-1:0] T_ONE  = {{(TB-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] C_ONE  = {{(CW-1){1'b0}}, 1'b1};

  localparam logic [2:0] IN_NONE = 3'b000;
  localparam logic [2:0] IN_AI   = 3'b001;
  localparam logic [2:0] IN_II   = 3'b010;
  localparam logic [2:0] IN_MI   = 3'b011;
  localparam logic [2:0] IN_XI   = 3'b100;
  localparam logic [2:0] IN_YI   = 3'b101;
  localparam logic [2:0] IN_DI   = 3'b110;
  localparam logic [2:0] IN_HALT = 3'b111;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } seq_state_t;

  seq_state_t     state_q;
  logic [TB-1:0]  tstate_q;
  logic [OPW-1:0] opcode_q;
  logic [CW-1:0]  count_q;

  logic       hold;
  logic [2:0] out_sel;
  logic [2:0] in_sel;
  logic       rt_raw;
  logic       pp_raw;
  logic       jmp_raw;
  logic       halt_dec;
  logic       unused_bits;

  assign hold      = stall | halted;
  assign out_sel   = uinstr[14:12];
  assign in_sel    = uinstr[7:5];
  assign halt_dec  = (in_sel == IN_HALT);

  // Field decode of the microinstruction; bit15 and bit8 are stored inverted.
  // Bus-out selects share the ALU flag field, so they only mean something while EO=0.
  always_comb begin
    EO        = ~uinstr[15];
    S8        = ~uinstr[8];
    ALU_flags = uinstr[14:9];
    JZ        = uinstr[4];
    JGT       = uinstr[3];
    JLT       = uinstr[2];
    PO        = 1'b0;
    IOH       = 1'b0;
    IOL       = 1'b0;
    MO        = 1'b0;
    DO        = 1'b0;
    rt_raw    = 1'b0;
    pp_raw    = 1'b0;
    if (!EO) begin
      rt_raw = uinstr[11];
      pp_raw = uinstr[10];
      case (out_sel)
        3'b000:  PO  = 1'b1;
        3'b001:  IOH = 1'b1;
        3'b010:  IOL = 1'b1;
        3'b011:  MO  = 1'b1;
        3'b110:  DO  = 1'b1;
        default: ;
      endcase
    end
    jmp_raw = (JZ & Z) | (JGT & ~Z & ~LT) | (JLT & LT);
  end

  // Side-effecting strobes are suppressed while the sequencer is held.
  always_comb begin
    AI  = 1'b0;
    II  = 1'b0;
    MI  = 1'b0;
    XI  = 1'b0;
    YI  = 1'b0;
    DI  = 1'b0;
    RT  = 1'b0;
    PP  = 1'b0;
    JMP = 1'b0;
    if (!hold) begin
      RT  = rt_raw;
      PP  = pp_raw;
      JMP = jmp_raw;
      case (in_sel)
        IN_AI:   AI = 1'b1;
        IN_II:   II = 1'b1;
        IN_MI:   MI = 1'b1;
        IN_XI:   XI = 1'b1;
        IN_YI:   YI = 1'b1;
        IN_DI:   DI = 1'b1;
        IN_NONE, IN_HALT: ;
        default: ;
      endcase
    end
  end

  generate
    if (UW > 16) begin : g_ext
      assign ext = uinstr[UW-1:16];
    end else begin : g_no_ext
      assign ext = '0;
    end
  endgenerate

  assign unused_bits = ^uinstr[1:0];

  // Sequencer: steps tstate, captures opcode on II, counts retired instructions.
  // HALT takes priority over RT on the same edge so tstate stays put.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      tstate_q <= T_ZERO;
      opcode_q <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (!stall) begin
            if (halt_dec) begin
              state_q <= ST_HALTED;
            end else begin
              if (rt_raw) begin
                tstate_q <= T_ZERO;
              end else begin
                tstate_q <= tstate_q + T_ONE;
              end
              if (rt_raw || (tstate_q == T_LAST)) begin
                count_q <= count_q + C_ONE;
              end
              if (in_sel == IN_II) begin
                opcode_q <= bus_in;
              end
            end
          end
        end
        ST_HALTED: ;
        default: state_q <= ST_HALTED;
      endcase
    end
  end

  assign halted      = (state_q == ST_HALTED);
  assign tstate      = tstate_q;
  assign uaddr       = {opcode_q, tstate_q};
  assign instr_count = count_q;

endmodule
